// File: rtl/lcd_rx_capture_pkg.sv
// Shared types for the LCD receive capture path: default panel geometry,
// FSM state encoding, FIFO word layout and the RGB888 -> RGB565 packer.
package lcd_rx_capture_pkg;

   localparam int H_ACTIVE_DEF = 480;
   localparam int V_ACTIVE_DEF = 272;
   localparam int PIX_W        = 18;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_SKIP    = 2'd2
   } state_t;

   // One FIFO entry: frame/line markers travel with the pixel.
   typedef struct packed {
      logic        sof;
      logic        eol;
      logic [15:0] data;
   } pix_t;

   // Truncating pack: {R[7:3], G[7:2], B[7:3]}.
   function automatic logic [15:0] pack565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

endpackage

// File: rtl/lcd_rx_capture_if.sv
// Pixel write stream toward the frame RAM write side.
// master: valid/data/sof/eol out, ready in.  slave: the reverse.
interface lcd_rx_capture_if;

   logic        valid;
   logic        ready;
   logic [15:0] data;
   logic        sof;
   logic        eol;

   modport master (
      output valid,
      output data,
      output sof,
      output eol,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  sof,
      input  eol,
      output ready
   );

endinterface

// File: rtl/lcd_rx_capture_sync_fifo.sv
// Show-ahead synchronous FIFO; head word visible while !empty, 0 when empty.
// Ports: clk, rst_n (sync, low), wr_en/wr_data, rd_en, rd_data, full, empty.
module lcd_rx_capture_sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/lcd_rx_capture.sv
// LCD RGB receiver: samples hs/vs/de/rgb, packs active pixels to RGB565
// with sof/eol markers into a FIFO and streams them out on ram_wr.
// Ports: lcd_clk, rst_n (sync, low), lcd_hs/vs/de/rgb in; ram_wr (master);
// frame_cnt (VS edges), overflow (sticky drop), geom_err (pulse).
// Optional: LCD_RX_GEOM_CHECK_EN builds the line/frame size checkers.
module lcd_rx_capture
   import lcd_rx_capture_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int FIFO_DEPTH = 16,
   parameter int SYNC_POL   = 0
) (
   input  logic              lcd_clk,
   input  logic              rst_n,
   input  logic              lcd_hs,
   input  logic              lcd_vs,
   input  logic              lcd_de,
   input  logic [23:0]       lcd_rgb,
   lcd_rx_capture_if.master  ram_wr,
   output logic [7:0]        frame_cnt,
   output logic              overflow,
   output logic              geom_err
);

   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW = $clog2(V_ACTIVE + 1) + 1;
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic VS_ON = (SYNC_POL != 0);

   logic        vs_s1;
   logic        vs_s2;
   logic        de_s1;
   logic        de_s2;
   logic        hs_s1_unused;
   logic [15:0] rgb_s1;
   logic        vs_edge;
   logic        de_fall;

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;

   state_t state_q;
   state_t state_d;

   logic p_vld;
   pix_t p_pix;
   pix_t head;
   logic cap;
   logic push;
   logic drop;
   logic pop;
   logic full;
   logic empty;

   // vs is stored as "asserted" so the edge logic is polarity-free.
   always_ff @(posedge lcd_clk) begin
      if (!rst_n) begin
         vs_s1        <= 1'b0;
         vs_s2        <= 1'b0;
         de_s1        <= 1'b0;
         de_s2        <= 1'b0;
         hs_s1_unused <= 1'b0;
         rgb_s1       <= '0;
      end else begin
         vs_s1        <= (lcd_vs == VS_ON);
         vs_s2        <= vs_s1;
         de_s1        <= lcd_de;
         de_s2        <= de_s1;
         hs_s1_unused <= lcd_hs;
         rgb_s1       <= pack565(lcd_rgb);
      end
   end

   assign vs_edge = vs_s1 & ~vs_s2;
   assign de_fall = de_s2 & ~de_s1;

   // y saturates so an overlong frame never aliases back to sof.
   always_ff @(posedge lcd_clk) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         frame_cnt <= '0;
      end else if (vs_edge) begin
         x_q       <= '0;
         y_q       <= '0;
         frame_cnt <= frame_cnt + 8'd1;
      end else if (de_s1) begin
         x_q <= (x_q == X_LAST) ? '0 : x_q + 1'b1;
      end else if (de_fall) begin
         x_q <= '0;
         y_q <= (&y_q) ? y_q : y_q + 1'b1;
      end
   end

   // Pixel stage: tagged pixel waits one cycle before the FIFO write.
   always_ff @(posedge lcd_clk) begin
      if (!rst_n) begin
         p_vld <= 1'b0;
         p_pix <= '0;
      end else begin
         p_vld      <= de_s1 && (state_q == ST_CAPTURE);
         p_pix.sof  <= (x_q == '0) && (y_q == '0);
         p_pix.eol  <= (x_q == X_LAST);
         p_pix.data <= rgb_s1;
      end
   end

   // A pop in the same cycle frees the slot, so full alone is no drop.
   assign pop  = ram_wr.ready && !empty;
   assign cap  = p_vld && (state_q == ST_CAPTURE);
   assign push = cap && (!full || pop);
   assign drop = cap && full && !pop;

   always_ff @(posedge lcd_clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (vs_edge) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (vs_edge)   state_d = ST_CAPTURE;
            else if (drop) state_d = ST_SKIP;
         end
         ST_SKIP: begin
            if (vs_edge) state_d = ST_CAPTURE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge lcd_clk) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

   lcd_rx_capture_sync_fifo #(
      .WIDTH (PIX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (lcd_clk),
      .rst_n   (rst_n),
      .wr_en   (push),
      .wr_data (p_pix),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   assign ram_wr.valid = !empty;
   assign ram_wr.data  = head.data;
   assign ram_wr.sof   = head.sof;
   assign ram_wr.eol   = head.eol;

`ifdef LCD_RX_GEOM_CHECK_EN
   localparam int LW = $clog2(H_ACTIVE + 1) + 1;
   localparam logic [LW-1:0] H_LEN   = LW'(H_ACTIVE);
   localparam logic [YW:0]   V_LINES = (YW+1)'(V_ACTIVE);

   logic [LW-1:0] pix_cnt;
   logic [YW:0]   lines;
   logic          seen_vs;
   logic          geom_q;
   logic          line_bad;
   logic          frame_bad;

   // A line ending on the VS edge cycle has not reached y yet.
   assign lines     = {1'b0, y_q} + {{YW{1'b0}}, de_fall};
   assign line_bad  = de_fall && (pix_cnt != H_LEN);
   assign frame_bad = vs_edge && seen_vs && (lines != V_LINES);

   always_ff @(posedge lcd_clk) begin
      if (!rst_n) begin
         pix_cnt <= '0;
         seen_vs <= 1'b0;
         geom_q  <= 1'b0;
      end else begin
         geom_q <= line_bad | frame_bad;
         if (vs_edge) begin
            seen_vs <= 1'b1;
         end
         if (de_fall || vs_edge) begin
            pix_cnt <= '0;
         end else if (de_s1) begin
            pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
         end
      end
   end

   assign geom_err = geom_q;
`else
   assign geom_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_rx_capture.sv
// Directed/randomized bench for lcd_rx_capture (H=8, V=4, FIFO=4).
// Expected pixel stream comes from a frame-level model of the spec.
module tb_lcd_rx_capture;
   import lcd_rx_capture_pkg::*;

   localparam int H = 8;
   localparam int V = 4;
   localparam int D = 4;

`ifdef LCD_RX_GEOM_CHECK_EN
   localparam int GEOM = 1;
`else
   localparam int GEOM = 0;
`endif

   logic        lcd_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        lcd_hs  = 1'b1;
   logic        lcd_vs  = 1'b1;
   logic        lcd_de  = 1'b0;
   logic [23:0] lcd_rgb = '0;
   logic [7:0]  frame_cnt;
   logic        overflow;
   logic        geom_err;

   lcd_rx_capture_if ram_wr();

   lcd_rx_capture #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .FIFO_DEPTH (D),
      .SYNC_POL   (0)
   ) dut (
      .lcd_clk   (lcd_clk),
      .rst_n     (rst_n),
      .lcd_hs    (lcd_hs),
      .lcd_vs    (lcd_vs),
      .lcd_de    (lcd_de),
      .lcd_rgb   (lcd_rgb),
      .ram_wr    (ram_wr),
      .frame_cnt (frame_cnt),
      .overflow  (overflow),
      .geom_err  (geom_err)
   );

   always #5 lcd_clk = ~lcd_clk;

   int checks = 0;
   int failures = 0;
   int fc = 0;
   int geom_pulses = 0;
   logic [17:0] exp_q[$];
   logic [17:0] recv_q[$];

   always @(negedge lcd_clk) begin
      if (rst_n && ram_wr.valid && ram_wr.ready)
         recv_q.push_back({ram_wr.sof, ram_wr.eol, ram_wr.data});
      if (geom_err)
         geom_pulses++;
   end

   function automatic logic [15:0] ref565(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

   task automatic tick();
      @(posedge lcd_clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic vsync();
      lcd_vs = 1'b0;
      tick();
      tick();
      lcd_vs = 1'b1;
      repeat (3) tick();
      fc = (fc + 1) % 256;
   endtask

   task automatic vs_pulse();
      lcd_vs = 1'b0;
      tick();
      lcd_vs = 1'b1;
      tick();
      fc = (fc + 1) % 256;
   endtask

   task automatic blank();
      lcd_de = 1'b0;
      lcd_hs = 1'b0;
      tick();
      tick();
      lcd_hs = 1'b1;
      repeat (6) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      fc = 0;
      recv_q.delete();
      exp_q.delete();
   endtask

   task automatic frame(input int lines, input int ppl, input bit ramp,
                        input bit cap, input int stall_max,
                        input int low_first, input bit lat_chk);
      int i;
      int st;
      logic [23:0] c;
      i = 0;
      vsync();
      for (int l = 0; l < lines; l++) begin
         st = stall_max;
         for (int p = 0; p < ppl; p++) begin
            c = ramp ? 24'hF8FC00 + 24'(i) : 24'($urandom);
            lcd_de  = 1'b1;
            lcd_rgb = c;
            if (l == 0 && p < low_first) begin
               ram_wr.ready = 1'b0;
            end else if (st > 0 && $urandom_range(0, 3) == 0) begin
               ram_wr.ready = 1'b0;
               st--;
            end else begin
               ram_wr.ready = 1'b1;
            end
            if (cap)
               exp_q.push_back({(p % H == 0) && (l == 0),
                                (p % H == H - 1), ref565(c)});
            tick();
            if (lat_chk && l == 0 && p == 1)
               check("latency_n1", ram_wr.valid, 0);
            if (lat_chk && l == 0 && p == 2)
               check("latency_n2", ram_wr.valid, 1);
            i++;
         end
         ram_wr.ready = 1'b1;
         blank();
      end
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_count"}, recv_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < recv_q.size(); k++)
         check($sformatf("%s[%0d]", tag, k), recv_q[k], exp_q[k]);
      exp_q.delete();
      recv_q.delete();
   endtask

   initial begin
      logic [23:0] c0;
      logic [23:0] c;

      ram_wr.ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_valid", ram_wr.valid, 0);
      check("rst_data", ram_wr.data, 0);
      check("rst_sof", ram_wr.sof, 0);
      check("rst_eol", ram_wr.eol, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_overflow", overflow, 0);
      check("rst_geom_err", geom_err, 0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // DE activity before any VS edge is ignored.
      for (int l = 0; l < 3; l++) begin
         for (int p = 0; p < H; p++) begin
            lcd_de  = 1'b1;
            lcd_rgb = 24'($urandom);
            tick();
         end
         blank();
      end
      check("pre_vs_pushes", recv_q.size(), 0);
      check("pre_vs_valid", ram_wr.valid, 0);
      check("pre_vs_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("pre_vs_frame_cnt", frame_cnt, 0);
      recv_q.delete();

      // Ramp frame with latency check.
      frame(V, H, 1'b1, 1'b1, 0, 0, 1'b1);
      repeat (6) tick();
      compare_stream("ramp");
      check("ramp_frame_cnt", frame_cnt, fc);
      check("ramp_overflow", overflow, 0);
      check("ramp_state", 32'(dut.state_q), 32'(ST_CAPTURE));

      // Random pixels with short sink stalls.
      repeat (2) frame(V, H, 1'b0, 1'b1, 2, 0, 1'b0);
      repeat (6) tick();
      compare_stream("rand_stall");
      check("rand_frame_cnt", frame_cnt, fc);
      check("rand_overflow", overflow, 0);

      // Overflow: sink stalled for the whole frame.
      vsync();
      ram_wr.ready = 1'b0;
      c0 = '0;
      for (int p = 0; p < H; p++) begin
         c = 24'($urandom);
         if (p == 0) c0 = c;
         lcd_de  = 1'b1;
         lcd_rgb = c;
         if (p < D)
            exp_q.push_back({p == 0, 1'b0, ref565(c)});
         tick();
         if (p == 5) check("ovf_before_5th", overflow, 0);
         if (p == 6) check("ovf_after_5th", overflow, 1);
      end
      blank();
      check("ovf_state_skip", 32'(dut.state_q), 32'(ST_SKIP));
      for (int l = 1; l < V; l++) begin
         for (int p = 0; p < H; p++) begin
            lcd_de  = 1'b1;
            lcd_rgb = 24'($urandom);
            tick();
         end
         blank();
      end
      check("stall_valid", ram_wr.valid, 1);
      check("stall_data", ram_wr.data, ref565(c0));
      check("stall_sof", ram_wr.sof, 1);
      check("stall_no_xfer", recv_q.size(), 0);
      ram_wr.ready = 1'b1;
      frame(V, H, 1'b0, 1'b1, 0, 0, 1'b0);
      repeat (6) tick();
      compare_stream("ovf_resume");
      check("ovf_sticky", overflow, 1);
      check("ovf_resume_state", 32'(dut.state_q), 32'(ST_CAPTURE));

      // Reset in the middle of a line.
      vsync();
      for (int p = 0; p < 4; p++) begin
         lcd_de  = 1'b1;
         lcd_rgb = 24'($urandom);
         tick();
      end
      rst_n = 1'b0;
      lcd_rgb = 24'($urandom);
      tick();
      check("midrst_valid", ram_wr.valid, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst_n = 1'b1;
      fc = 0;
      recv_q.delete();
      exp_q.delete();
      for (int p = 5; p < H; p++) begin
         lcd_de  = 1'b1;
         lcd_rgb = 24'($urandom);
         tick();
      end
      blank();
      for (int p = 0; p < H; p++) begin
         lcd_de  = 1'b1;
         lcd_rgb = 24'($urandom);
         tick();
      end
      blank();
      check("midrst_no_resume", recv_q.size(), 0);
      check("midrst_idle", 32'(dut.state_q), 32'(ST_IDLE));

      // Push and pop together while the FIFO is full.
      do_reset();
      frame(V, H, 1'b0, 1'b1, 0, 6, 1'b0);
      repeat (6) tick();
      compare_stream("full_push_pop");
      check("full_push_pop_ovf", overflow, 0);

      // Frame counter and wrap.
      do_reset();
      repeat (3) vs_pulse();
      tick();
      check("frame_cnt_3", frame_cnt, fc);
      repeat (252) vs_pulse();
      tick();
      check("frame_cnt_255", frame_cnt, fc);
      vs_pulse();
      tick();
      check("frame_cnt_wrap", frame_cnt, 0);

      // Geometry: short line, short frame, then a good frame.
      do_reset();
      geom_pulses = 0;
      frame(1, H - 1, 1'b0, 1'b1, 0, 0, 1'b0);
      check("geom_short_line", geom_pulses, GEOM * 1);
      frame(V - 1, H, 1'b0, 1'b1, 0, 0, 1'b0);
      check("geom_after_1line", geom_pulses, GEOM * 2);
      frame(V, H, 1'b0, 1'b1, 0, 0, 1'b0);
      check("geom_short_frame", geom_pulses, GEOM * 3);
      vsync();
      repeat (4) tick();
      check("geom_good_frame", geom_pulses, GEOM * 3);
      compare_stream("geom_stream");
      check("geom_frame_cnt", frame_cnt, fc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
